// File: rtl/ysyx_mem_arbiter.sv
// rtl/ysyx_mem_arbiter.sv - two-master (IFU/LSU) round-robin arbiter onto one memory port
// One transaction in flight; request fields registered, response buffered until the owner takes it.
module ysyx_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_resp_valid,
    input  logic                ifu_resp_ready,
    output logic [DATA_W-1:0]   ifu_rdata,
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic                lsu_wen,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_resp_valid,
    input  logic                lsu_resp_ready,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_resp_valid,
    output logic                mem_resp_ready,
    input  logic [DATA_W-1:0]   mem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, RESP, HOLD} state_t;

    state_t              state, state_nxt;
    logic                owner_lsu;
    logic                prio_lsu;
    logic [DATA_W-1:0]   rdata_buf;
    logic                grant_ifu, grant_lsu;
    logic                owner_resp_ready;

    always_comb begin
        state_nxt        = state;
        grant_ifu        = 1'b0;
        grant_lsu        = 1'b0;
        ifu_req_ready    = 1'b0;
        lsu_req_ready    = 1'b0;
        mem_req_valid    = 1'b0;
        mem_resp_ready   = 1'b0;
        ifu_resp_valid   = 1'b0;
        lsu_resp_valid   = 1'b0;
        owner_resp_ready = owner_lsu ? lsu_resp_ready : ifu_resp_ready;
        case (state)
            IDLE: begin
                // prio_lsu is set when the IFU owned the last completed transaction
                grant_ifu     = ifu_req_valid && (!lsu_req_valid || !prio_lsu);
                grant_lsu     = lsu_req_valid && !grant_ifu;
                ifu_req_ready = grant_ifu;
                lsu_req_ready = grant_lsu;
                if (grant_ifu || grant_lsu) state_nxt = REQ;
            end
            REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) state_nxt = RESP;
            end
            RESP: begin
                mem_resp_ready = 1'b1;
                if (mem_resp_valid) state_nxt = HOLD;
            end
            HOLD: begin
                ifu_resp_valid = !owner_lsu;
                lsu_resp_valid = owner_lsu;
                if (owner_resp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            owner_lsu <= 1'b0;
            prio_lsu  <= 1'b0;
            rdata_buf <= '0;
            mem_addr  <= '0;
            mem_wen   <= 1'b0;
            mem_wdata <= '0;
            mem_wmask <= '0;
        end else begin
            state <= state_nxt;
            if (grant_ifu) begin
                mem_addr  <= ifu_addr;
                mem_wen   <= 1'b0;
                mem_wdata <= '0;
                mem_wmask <= '0;
                owner_lsu <= 1'b0;
            end else if (grant_lsu) begin
                mem_addr  <= lsu_addr;
                mem_wen   <= lsu_wen;
                mem_wdata <= lsu_wdata;
                mem_wmask <= lsu_wmask;
                owner_lsu <= 1'b1;
            end
            if (state == RESP && mem_resp_valid)
                rdata_buf <= mem_wen ? '0 : mem_rdata;
            if (state == HOLD && owner_resp_ready)
                prio_lsu <= !owner_lsu;
        end
    end

    assign ifu_rdata = owner_lsu ? '0 : rdata_buf;
    assign lsu_rdata = owner_lsu ? rdata_buf : '0;

endmodule

// File: tb/tb_ysyx_mem_arbiter.sv
// tb/tb_ysyx_mem_arbiter.sv - directed scoreboard bench for ysyx_mem_arbiter
// Cycle-stepped environment: memory and master response models plus an expected-result queue.
module tb_ysyx_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready;
    logic [31:0] ifu_addr, ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_ready;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [3:0]  lsu_wmask;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid, mem_resp_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wmask;

    always #5 clk = ~clk;

    ysyx_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready), .ifu_rdata(ifu_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready), .lsu_rdata(lsu_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready), .mem_rdata(mem_rdata)
    );

    typedef struct packed {
        logic        lsu;
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];
    bit   grant_log[$];
    int   errors = 0, checks = 0, cyc = 0;
    int   req_stall = 0, resp_stall = 0, ifu_rr_stall = 0, lsu_rr_stall = 0;
    int   req_wait = 0, resp_wait = 0, rr_wait = 0;
    bit   busy = 0, seen_req = 0;
    int   req_cyc = 0, last_time = 0, last_grant_cyc = -100, grant_gap = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        return (a == 32'h8000_0000) ? 32'h0000_0413 : (a ^ 32'hA5A5_5A5A);
    endfunction

    // One clock: drive memory/master responses, sample mid-cycle, update scoreboard, advance.
    task automatic cycle();
        exp_t e;
        bit   rsp_hs;
        mem_req_ready  = mem_req_valid && (req_wait >= req_stall);
        mem_resp_valid = mem_resp_ready ? (resp_wait >= resp_stall) : 1'($urandom_range(0, 1));
        mem_rdata      = mem_model(mem_addr);
        ifu_resp_ready = ifu_resp_valid && (rr_wait >= ifu_rr_stall);
        lsu_resp_ready = lsu_resp_valid && (rr_wait >= lsu_rr_stall);
        #2;
        if (busy) chk("req_ready_while_busy", 64'({ifu_req_ready, lsu_req_ready}), 64'(0));
        if (mem_req_valid) begin
            if (sb.size() == 0) chk("mem_req_unexpected", 64'(1), 64'(0));
            else begin
                chk("mem_addr", 64'(mem_addr), 64'(sb[0].addr));
                chk("mem_wen", 64'(mem_wen), 64'(sb[0].wen));
                chk("mem_wdata", 64'(mem_wdata), 64'(sb[0].wdata));
                chk("mem_wmask", 64'(mem_wmask), 64'(sb[0].wmask));
                if (!seen_req) begin
                    chk("mem_req_latency", 64'(cyc - req_cyc), 64'(1));
                    seen_req = 1;
                end
            end
        end
        rsp_hs = (ifu_resp_valid && ifu_resp_ready) || (lsu_resp_valid && lsu_resp_ready);
        if (rsp_hs) begin
            if (sb.size() == 0) chk("resp_unexpected", 64'(1), 64'(0));
            else begin
                e = sb.pop_front();
                chk("resp_owner", 64'(lsu_resp_valid), 64'(e.lsu));
                chk("resp_nonowner_quiet", 64'(e.lsu ? ifu_resp_valid : lsu_resp_valid), 64'(0));
                chk("resp_rdata", 64'(e.lsu ? lsu_rdata : ifu_rdata), 64'(e.rdata));
                last_time = cyc - req_cyc + 1;
                busy = 0;
            end
        end
        if (ifu_req_valid && ifu_req_ready) begin
            sb.push_back(exp_t'{lsu: 1'b0, addr: ifu_addr, wen: 1'b0, wdata: 32'h0,
                                wmask: 4'h0, rdata: mem_model(ifu_addr)});
            grant_log.push_back(1'b0);
        end
        if (lsu_req_valid && lsu_req_ready) begin
            sb.push_back(exp_t'{lsu: 1'b1, addr: lsu_addr, wen: lsu_wen, wdata: lsu_wdata,
                                wmask: lsu_wmask, rdata: lsu_wen ? 32'h0 : mem_model(lsu_addr)});
            grant_log.push_back(1'b1);
        end
        if ((ifu_req_valid && ifu_req_ready) || (lsu_req_valid && lsu_req_ready)) begin
            busy = 1; seen_req = 0; req_cyc = cyc;
            grant_gap = cyc - last_grant_cyc; last_grant_cyc = cyc;
        end
        if (mem_req_valid) req_wait = mem_req_ready ? 0 : req_wait + 1;
        if (mem_resp_ready) resp_wait = mem_resp_valid ? 0 : resp_wait + 1;
        if (ifu_resp_valid || lsu_resp_valid) rr_wait = rsp_hs ? 0 : rr_wait + 1;
        @(posedge clk);
        #2;
        cyc++;
    endtask

    task automatic drain(input int max);
        int n = 0;
        while ((busy || sb.size() != 0) && n < max) begin
            cycle();
            n++;
        end
        chk("drain_timeout", 64'(busy || sb.size() != 0), 64'(0));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valids"}, 64'({mem_req_valid, mem_resp_ready, ifu_resp_valid, lsu_resp_valid}), 64'(0));
        chk({tag, "_mem_fields"}, 64'({mem_addr, mem_wen, mem_wmask} | 64'(mem_wdata)), 64'(0));
        chk({tag, "_rdata"}, {ifu_rdata, lsu_rdata}, 64'(0));
    endtask

    initial begin
        int n;
        int prev;
        // Reset with random inputs
        rst = 1'b0;
        ifu_req_valid = 1'($urandom_range(0, 1)); lsu_req_valid = 1'($urandom_range(0, 1));
        ifu_addr = $urandom; lsu_addr = $urandom; lsu_wen = 1'($urandom_range(0, 1));
        lsu_wdata = $urandom; lsu_wmask = 4'($urandom); mem_rdata = $urandom;
        mem_req_ready = 1'($urandom_range(0, 1)); mem_resp_valid = 1'($urandom_range(0, 1));
        ifu_resp_ready = 1'($urandom_range(0, 1)); lsu_resp_ready = 1'($urandom_range(0, 1));
        repeat (2) @(posedge clk);
        #2;
        check_reset_outputs("reset");

        // Release with only the IFU requesting; grant is combinational
        ifu_req_valid = 1'b1; lsu_req_valid = 1'b0; lsu_wen = 1'b0;
        ifu_addr = 32'h8000_0000; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("reset_release_ifu_ready", 64'(ifu_req_ready), 64'(1));
        chk("reset_release_lsu_ready", 64'(lsu_req_ready), 64'(0));

        // IFU fetch, zero wait
        cycle();
        ifu_req_valid = 1'b0;
        drain(30);
        chk("ifu_fetch_time", 64'(last_time), 64'(4));

        // LSU write
        lsu_req_valid = 1'b1; lsu_addr = 32'h8000_1000; lsu_wen = 1'b1;
        lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'hF;
        cycle();
        lsu_req_valid = 1'b0; lsu_wen = 1'b0;
        drain(30);
        chk("lsu_write_time", 64'(last_time), 64'(4));

        // Both request continuously: IFU, LSU, IFU with no bubble
        grant_log.delete();
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0004;
        lsu_req_valid = 1'b1; lsu_addr = 32'h8000_2000;
        n = 0;
        while (grant_log.size() < 3 && n < 40) begin
            prev = grant_log.size();
            cycle();
            if (grant_log.size() > prev && grant_log.size() > 1)
                chk("b2b_grant_gap", 64'(grant_gap), 64'(4));
            n++;
        end
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        drain(30);
        chk("rr_grant_count", 64'(grant_log.size()), 64'(3));
        if (grant_log.size() == 3)
            chk("rr_grant_order", 64'({grant_log[0], grant_log[1], grant_log[2]}), 64'(3'b010));

        // Stalled LSU read, with both masters pending while busy
        req_stall = 3; resp_stall = 2; lsu_rr_stall = 2;
        lsu_req_valid = 1'b1; lsu_addr = 32'h8000_3000;
        cycle();
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0010;
        n = 0;
        while (busy && n < 40) begin
            cycle();
            n++;
        end
        chk("stall_txn_time", 64'(last_time), 64'(11));
        req_stall = 0; resp_stall = 0; lsu_rr_stall = 0;
        grant_log.delete();
        cycle();
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        chk("post_stall_grant_count", 64'(grant_log.size()), 64'(1));
        if (grant_log.size() == 1) chk("post_stall_grant_ifu", 64'(grant_log[0]), 64'(0));
        drain(30);

        // Reset while waiting in RESP
        resp_stall = 6;
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0008;
        cycle();
        ifu_req_valid = 1'b0;
        n = 0;
        while (!mem_resp_ready && n < 20) begin
            cycle();
            n++;
        end
        chk("reached_resp", 64'(mem_resp_ready), 64'(1));
        rst = 1'b0;
        #1;
        check_reset_outputs("mid_resp_reset");
        sb.delete(); busy = 0;
        resp_stall = 0; req_wait = 0; resp_wait = 0; rr_wait = 0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        repeat (3) cycle();
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000;
        cycle();
        ifu_req_valid = 1'b0;
        drain(30);
        chk("after_reset_fetch_time", 64'(last_time), 64'(4));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
